// File: rtl/e203_exu_fpu_fmul_iter.sv
// rtl/e203_exu_fpu_fmul_iter.sv - iterative IEEE-754 multiplier, one stage per FSM state.
// Define E203_FPU_FMUL_SUBNORM_EN for full subnormal support; otherwise subnormals flush to zero.
module e203_exu_fpu_fmul_iter #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int FLEN  = 1 + EXP_W + MAN_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fmul_i_valid,
    output logic            fmul_i_ready,
    input  logic [FLEN-1:0] fmul_i_rs1,
    input  logic [FLEN-1:0] fmul_i_rs2,
    input  logic [2:0]      fmul_i_rm,
    output logic            fmul_o_valid,
    input  logic            fmul_o_ready,
    output logic [FLEN-1:0] fmul_o_wbck_wdat,
    output logic [4:0]      fmul_o_fflags
);
    localparam int MW1 = MAN_W + 1;
    localparam int PW  = 2 * MW1;
    localparam int EW  = EXP_W + 3;
    localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE  = EW'(1);
    localparam logic signed [EW-1:0] ZERO = EW'(0);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_UNPACK   = 4'd1;
    localparam logic [3:0] S_SPECIAL  = 4'd2;
    localparam logic [3:0] S_NORM_IN  = 4'd3;
    localparam logic [3:0] S_MUL      = 4'd4;
    localparam logic [3:0] S_NORM_OUT = 4'd5;
    localparam logic [3:0] S_ROUND    = 4'd6;
    localparam logic [3:0] S_PACK     = 4'd7;
    localparam logic [3:0] S_OUT      = 4'd8;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam logic [FLEN-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic [3:0]            state;
    logic [FLEN-1:0]       a, b;
    logic [2:0]            rm_q;
    logic                  sgn;
    logic signed [EW-1:0]  e1, e2, ep;
    logic [MW1-1:0]        m1, m2, mr;
    logic [PW-1:0]         p;
    logic                  sticky, nout_first, flush, nx;

    assign fmul_i_ready = (state == S_IDLE);

    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, inv_op;
    assign a_exp  = a[FLEN-2 -: EXP_W];
    assign b_exp  = b[FLEN-2 -: EXP_W];
    assign a_frac = a[MAN_W-1:0];
    assign b_frac = b[MAN_W-1:0];
    assign a_nan  = (&a_exp) & (|a_frac);
    assign b_nan  = (&b_exp) & (|b_frac);
    assign a_snan = a_nan & ~a_frac[MAN_W-1];
    assign b_snan = b_nan & ~b_frac[MAN_W-1];
    assign a_inf  = (&a_exp) & ~(|a_frac);
    assign b_inf  = (&b_exp) & ~(|b_frac);
`ifdef E203_FPU_FMUL_SUBNORM_EN
    assign a_zero = (a_exp == '0) & ~(|a_frac);
    assign b_zero = (b_exp == '0) & ~(|b_frac);
`else
    // Subnormal operands count as zero here, so they never reach the datapath.
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
`endif
    assign inv_op = (a_inf & b_zero) | (a_zero & b_inf);

    logic signed [EW-1:0] e_norm;
    assign e_norm = p[PW-1] ? ep + ONE : ep;

    logic [MW1-1:0] m_cur;
    logic [MW1:0]   m_sum;
    logic           g_bit, s_bit, round_up, inexact;
    always_comb begin
        m_cur   = p[PW-1 -: MW1];
        g_bit   = p[MAN_W];
        s_bit   = sticky | (|p[MAN_W-1:0]);
        inexact = g_bit | s_bit;
        case (rm_q)
            RM_RTZ:  round_up = 1'b0;
            RM_RDN:  round_up = sgn & inexact;
            RM_RUP:  round_up = ~sgn & inexact;
            RM_RMM:  round_up = g_bit;
            default: round_up = g_bit & (s_bit | m_cur[0]);
        endcase
        m_sum = {1'b0, m_cur} + {{MW1{1'b0}}, round_up};
    end

    logic [FLEN-1:0]  pack_res, inf_res, maxf_res;
    logic [4:0]       pack_flags;
    logic [EXP_W-1:0] exp_out;
    always_comb begin
        inf_res    = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        maxf_res   = {sgn, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        exp_out    = mr[MAN_W] ? ep[EXP_W-1:0] : {EXP_W{1'b0}};
        pack_res   = {sgn, exp_out, mr[MAN_W-1:0]};
        pack_flags = {3'b000, ~mr[MAN_W] & nx, nx};
        if (flush) begin
            pack_res   = {sgn, {(FLEN-1){1'b0}}};
            pack_flags = 5'b00011;
        end else if (ep >= EMAX) begin
            pack_flags = 5'b00101;
            case (rm_q)
                RM_RTZ:  pack_res = maxf_res;
                RM_RDN:  pack_res = sgn ? inf_res : maxf_res;
                RM_RUP:  pack_res = sgn ? maxf_res : inf_res;
                default: pack_res = inf_res;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            a                <= '0;
            b                <= '0;
            rm_q             <= RM_RNE;
            sgn              <= 1'b0;
            e1               <= '0;
            e2               <= '0;
            ep               <= '0;
            m1               <= '0;
            m2               <= '0;
            mr               <= '0;
            p                <= '0;
            sticky           <= 1'b0;
            nout_first       <= 1'b0;
            flush            <= 1'b0;
            nx               <= 1'b0;
            fmul_o_valid     <= 1'b0;
            fmul_o_wbck_wdat <= '0;
            fmul_o_fflags    <= '0;
        end else begin
            case (state)
                S_IDLE: if (fmul_i_valid) begin
                    a     <= fmul_i_rs1;
                    b     <= fmul_i_rs2;
                    rm_q  <= (fmul_i_rm > RM_RMM) ? RM_RNE : fmul_i_rm;
                    state <= S_UNPACK;
                end
                S_UNPACK: begin
                    sgn   <= a[FLEN-1] ^ b[FLEN-1];
                    e1    <= (a_exp == '0) ? ONE : {{(EW-EXP_W){1'b0}}, a_exp};
                    e2    <= (b_exp == '0) ? ONE : {{(EW-EXP_W){1'b0}}, b_exp};
                    m1    <= {(a_exp != '0), a_frac};
                    m2    <= {(b_exp != '0), b_frac};
                    state <= S_SPECIAL;
                end
                S_SPECIAL: begin
                    if (a_nan | b_nan | inv_op) begin
                        fmul_o_wbck_wdat <= QNAN;
                        fmul_o_fflags    <= {a_snan | b_snan | inv_op, 4'b0000};
                        fmul_o_valid     <= 1'b1;
                        state            <= S_OUT;
                    end else if (a_inf | b_inf) begin
                        fmul_o_wbck_wdat <= {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        fmul_o_fflags    <= '0;
                        fmul_o_valid     <= 1'b1;
                        state            <= S_OUT;
                    end else if (a_zero | b_zero) begin
                        fmul_o_wbck_wdat <= {sgn, {(FLEN-1){1'b0}}};
                        fmul_o_fflags    <= '0;
                        fmul_o_valid     <= 1'b1;
                        state            <= S_OUT;
                    end else begin
                        state <= S_NORM_IN;
                    end
                end
                S_NORM_IN: begin
`ifdef E203_FPU_FMUL_SUBNORM_EN
                    if (m1[MAN_W] && m2[MAN_W]) begin
                        state <= S_MUL;
                    end else begin
                        if (!m1[MAN_W]) begin
                            m1 <= m1 << 1;
                            e1 <= e1 - ONE;
                        end
                        if (!m2[MAN_W]) begin
                            m2 <= m2 << 1;
                            e2 <= e2 - ONE;
                        end
                    end
`else
                    state <= S_MUL;
`endif
                end
                S_MUL: begin
                    p          <= {{MW1{1'b0}}, m1} * {{MW1{1'b0}}, m2};
                    ep         <= e1 + e2 - BIAS;
                    sticky     <= 1'b0;
                    nout_first <= 1'b1;
                    flush      <= 1'b0;
                    state      <= S_NORM_OUT;
                end
                S_NORM_OUT: begin
                    // First pass left-aligns the hidden bit at p[PW-1]; later passes denormalise.
                    if (nout_first) begin
                        nout_first <= 1'b0;
                        if (p[PW-1]) ep <= ep + ONE;
                        else         p  <= p << 1;
`ifdef E203_FPU_FMUL_SUBNORM_EN
                        if (e_norm >= ONE) state <= S_ROUND;
`else
                        flush <= (e_norm < ONE);
                        state <= S_ROUND;
`endif
                    end else begin
                        p      <= p >> 1;
                        sticky <= sticky | p[0];
                        ep     <= ep + ONE;
                        if (ep >= ZERO) state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    nx <= inexact;
                    if (m_sum[MW1]) begin
                        mr <= m_sum[MW1:1];
                        ep <= ep + ONE;
                    end else begin
                        mr <= m_sum[MW1-1:0];
                    end
                    state <= S_PACK;
                end
                S_PACK: begin
                    fmul_o_wbck_wdat <= pack_res;
                    fmul_o_fflags    <= pack_flags;
                    fmul_o_valid     <= 1'b1;
                    state            <= S_OUT;
                end
                S_OUT: if (fmul_o_ready) begin
                    fmul_o_valid <= 1'b0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_e203_exu_fpu_fmul_iter.sv
// tb/tb_e203_exu_fpu_fmul_iter.sv - directed-vector bench for e203_exu_fpu_fmul_iter.
module tb_e203_exu_fpu_fmul_iter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [2:0]  rm = '0;
    logic        o_valid;
    logic        o_ready = 1'b0;
    logic [31:0] wdat;
    logic [4:0]  fflags;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    e203_exu_fpu_fmul_iter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fmul_i_valid     (i_valid),
        .fmul_i_ready     (i_ready),
        .fmul_i_rs1       (rs1),
        .fmul_i_rs2       (rs2),
        .fmul_i_rm        (rm),
        .fmul_o_valid     (o_valid),
        .fmul_o_ready     (o_ready),
        .fmul_o_wbck_wdat (wdat),
        .fmul_o_fflags    (fflags)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!o_valid && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic [2:0] mode, input logic [31:0] exp_res,
                          input logic [4:0] exp_flags, input int exp_lat);
        int lat;
        @(negedge clk);
        check({tag, " i_ready"}, 32'(i_ready), 32'd1);
        rs1 = x; rs2 = y; rm = mode; i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        wait_valid(lat);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, wdat, exp_res);
        check({tag, " fflags"}, 32'(fflags), 32'(exp_flags));
        @(negedge clk);
        o_ready = 1'b1;
        @(posedge clk);
        #1;
        o_ready = 1'b0;
        check({tag, " valid drop"}, 32'(o_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] held;
        #12;
        check("reset valid", 32'(o_valid), 32'd0);
        check("reset wdat", wdat, 32'h0);
        check("reset fflags", 32'(fflags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset ready", 32'(i_ready), 32'd1);

        run_op("1.5x2",      32'h3FC00000, 32'h40000000, 3'b000, 32'h40400000, 5'h00, 7);
        run_op("-1.5x2",     32'hBFC00000, 32'h40000000, 3'b000, 32'hC0400000, 5'h00, 7);
        run_op("inf*0",      32'h7F800000, 32'h00000000, 3'b000, 32'h7FC00000, 5'h10, 2);
        run_op("snan",       32'h7FA00000, 32'h3F800000, 3'b000, 32'h7FC00000, 5'h10, 2);
        run_op("inf*-2",     32'h7F800000, 32'hC0000000, 3'b000, 32'hFF800000, 5'h00, 2);
        run_op("-0*1",       32'h80000000, 32'h3F800000, 3'b000, 32'h80000000, 5'h00, 2);
        run_op("ovf rne",    32'h7F7FFFFF, 32'h40000000, 3'b000, 32'h7F800000, 5'h05, 7);
        run_op("ovf rtz",    32'h7F7FFFFF, 32'h40000000, 3'b001, 32'h7F7FFFFF, 5'h05, 7);
        run_op("ovf rdn",    32'hFF7FFFFF, 32'h40000000, 3'b010, 32'hFF800000, 5'h05, 7);
        run_op("ovf rup neg",32'hFF7FFFFF, 32'h40000000, 3'b011, 32'hFF7FFFFF, 5'h05, 7);
        run_op("nx rne",     32'h3F800001, 32'h3F800001, 3'b000, 32'h3F800002, 5'h01, 7);
        run_op("nx rup",     32'h3F800001, 32'h3F800001, 3'b011, 32'h3F800003, 5'h01, 7);
        run_op("nx rm111",   32'h3F800001, 32'h3F800001, 3'b111, 32'h3F800002, 5'h01, 7);
        run_op("nx rmm",     32'h3F800001, 32'h3F800001, 3'b100, 32'h3F800002, 5'h01, 7);
`ifdef E203_FPU_FMUL_SUBNORM_EN
        run_op("tiny out",   32'h00800000, 32'h3F000000, 3'b000, 32'h00400000, 5'h00, 8);
        run_op("subn in",    32'h00000001, 32'h4B000000, 3'b000, 32'h00800000, 5'h00, 30);
`else
        run_op("tiny out",   32'h00800000, 32'h3F000000, 3'b000, 32'h00000000, 5'h03, 7);
        run_op("subn in",    32'h00000001, 32'h4B000000, 3'b000, 32'h00000000, 5'h00, 2);
`endif

        // Back-pressure: result must hold while o_ready is low, new requests ignored.
        @(negedge clk);
        rs1 = 32'h3FC00000; rs2 = 32'h40000000; rm = 3'b000; i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        wait_valid(lat);
        check("stall latency", 32'(lat), 32'd7);
        held = wdat;
        check("stall first", held, 32'h40400000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rs1 = 32'h40000000; rs2 = 32'h40000000; i_valid = 1'b1;
            @(posedge clk);
            #1;
            check("stall wdat", wdat, 32'h40400000);
            check("stall fflags", 32'(fflags), 32'd0);
            check("stall valid", 32'(o_valid), 32'd1);
            check("stall i_ready", 32'(i_ready), 32'd0);
        end
        @(negedge clk);
        i_valid = 1'b0;
        o_ready = 1'b1;
        @(posedge clk);
        #1;
        o_ready = 1'b0;
        check("stall release", 32'(o_valid), 32'd0);

        // Reset while the operation sits in MUL.
        @(negedge clk);
        rs1 = 32'h3FC00000; rs2 = 32'h40000000; i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst valid", 32'(o_valid), 32'd0);
        check("rst wdat", wdat, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst ready", 32'(i_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (o_valid) seen++;
        end
        check("rst no result", 32'(seen), 32'd0);
        run_op("after rst",  32'h3FC00000, 32'h40000000, 3'b000, 32'h40400000, 5'h00, 7);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/e203_exu_fpu_fmul_iter.md
E203_EXU_FPU_FMUL_ITER -- requirements
Module: e203_exu_fpu_fmul_iter

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, fraction field width; FLEN = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port fmul_i_valid  input  1  operand request valid.
REQ-006 SHALL have port fmul_i_ready  output  1  operand request ready.
REQ-007 SHALL have ports fmul_i_rs1 and fmul_i_rs2, each input  FLEN  IEEE-754 operand.
REQ-008 SHALL have port fmul_i_rm  input  3  rounding mode: RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100.
REQ-009 SHALL have port fmul_o_valid  output  1  result valid.
REQ-010 SHALL have port fmul_o_ready  input  1  result ready.
REQ-011 SHALL have port fmul_o_wbck_wdat  output  FLEN  product.
REQ-012 SHALL have port fmul_o_fflags  output  5  {NV,DZ,OF,UF,NX}; bit 4 = NV.

Function
REQ-013 SHALL implement FSM states IDLE, UNPACK, SPECIAL, NORM_IN, MUL, NORM_OUT, ROUND, PACK, OUT.
REQ-014 SHALL drive fmul_i_ready = (state==IDLE), with no combinational dependence on fmul_o_ready.
REQ-015 SHALL capture rs1, rs2 and rm on the edge where fmul_i_valid & fmul_i_ready, then move to UNPACK.
REQ-016 SHALL treat rm encodings 101, 110 and 111 as RNE.
REQ-017 SHALL resolve NaN, infinity and zero operands in SPECIAL and go directly to OUT.
- Special-case latency: fmul_o_valid high 2 edges after the accepting edge.
REQ-018 SHALL return the canonical quiet NaN (sign 0, exponent all ones, fraction MSB 1, rest 0) for any NaN result.
- NV set for an sNaN input or inf*0.
REQ-019 SHALL give sign = rs1 sign XOR rs2 sign for every non-NaN result, including zero and infinity.
REQ-020 SHALL shift subnormal mantissas left in NORM_IN, one bit per cycle per operand, decrementing the exponent each step.
REQ-021 SHALL form the full (MAN_W+1)x(MAN_W+1) product in one MUL cycle.
REQ-022 SHALL apply a single 1-bit normalising shift in NORM_OUT.
- Then right-shift 1 bit/cycle while exponent < emin (subnormal output), accumulating guard/round/sticky.
REQ-023 SHALL round in ROUND per the latched rm; mantissa carry-out increments the exponent.
REQ-024 SHALL give normal-operand latency of exactly 7 edges after the accepting edge, plus one cycle per NORM_IN or subnormal-output shift step.
REQ-025 SHALL handle overflow as follows:
- RNE/RMM: signed infinity.
- RTZ: signed max-finite.
- RDN: +max-finite or -infinity.
- RUP: +infinity or -max-finite.
- OF and NX set in all cases.
REQ-026 SHALL set NX when any rounded-off bit is nonzero; UF when result is tiny (after rounding) and inexact; DZ always 0.
REQ-027 SHALL hold fmul_o_valid, fmul_o_wbck_wdat and fmul_o_fflags stable in OUT until fmul_o_ready.
- The handshake edge returns the FSM to IDLE and deasserts fmul_o_valid.
REQ-028 SHALL ignore fmul_i_valid in every state other than IDLE.

Reset
REQ-029 SHALL on rst_n low asynchronously force state=IDLE, fmul_o_valid=0, fmul_o_wbck_wdat=0 and fmul_o_fflags=0.
REQ-030 SHALL abandon any in-flight operation on reset and produce no result for it.
- fmul_i_ready reads 1 in the first cycle after rst_n deassertion.

Configuration
REQ-031 SHALL, with macro E203_FPU_FMUL_SUBNORM_EN defined, fully support subnormal inputs and outputs per REQ-020/022.
REQ-032 SHALL, without E203_FPU_FMUL_SUBNORM_EN, handle subnormals in flush-to-zero mode:
- Subnormal inputs are treated as signed zero; NORM_IN takes 1 cycle.
- Results tiny before rounding become signed zero with UF|NX set.

Verification (FLEN=32 defaults)
REQ-033 SHALL cover: 0x3FC00000*0x40000000, RNE -> 0x40400000, fflags 0x00, fmul_o_valid 7 edges after accept.
REQ-034 SHALL cover: 0x7F800000*0x00000000 -> 0x7FC00000, fflags 0x10, latency 2; 0x7FA00000*0x3F800000 -> 0x7FC00000, fflags 0x10.
REQ-035 SHALL cover: 0x7F7FFFFF*0x40000000 -> RNE 0x7F800000, RTZ 0x7F7FFFFF, RDN with rs1 0xFF7FFFFF -> 0xFF800000; fflags 0x05 in all cases.
REQ-036 SHALL cover: 0x3F800001*0x3F800001 -> RNE 0x3F800002 and RUP 0x3F800003, fflags 0x01.
REQ-037 SHALL cover: 0x00800000*0x3F000000, RNE -> with SUBNORM_EN 0x00400000, fflags 0x00; without it 0x00000000, fflags 0x03.
REQ-038 SHALL cover: fmul_o_ready low for 5 cycles -> outputs stable and fmul_i_ready 0.
- Then rst_n pulsed during MUL -> fmul_o_valid 0 and no result emitted.
- fmul_i_ready 1 after release.
